// File: rtl/morse_entry_buffer_if.sv
// Button inputs and packed symbol-buffer outputs of the Morse entry buffer.
// The master side drives the buttons; the slave side is the buffer itself.
interface morse_entry_buffer_if #(
    parameter int NUM_SLOTS = 8,
    parameter int MAX_ELEMS = 4,
    parameter int LEN_W     = $clog2(MAX_ELEMS + 1),
    parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
);
    logic                           btn_dot;
    logic                           btn_dash;
    logic                           btn_commit;
    logic                           btn_back;
    logic [NUM_SLOTS*MAX_ELEMS-1:0] fsm_in;
    logic [NUM_SLOTS*LEN_W-1:0]     bits;
    logic [CNT_W-1:0]               count;
    logic [MAX_ELEMS-1:0]           cur_code;
    logic [LEN_W-1:0]               cur_len;
    logic                           full;
    logic                           err;

    modport master (
        output btn_dot, btn_dash, btn_commit, btn_back,
        input  fsm_in, bits, count, cur_code, cur_len, full, err
    );

    modport slave (
        input  btn_dot, btn_dash, btn_commit, btn_back,
        output fsm_in, bits, count, cur_code, cur_len, full, err
    );
endinterface

// File: rtl/morse_entry_buffer.sv
// Captures dot/dash presses into a current symbol and commits symbols into a
// NUM_SLOTS-deep buffer, with backspace, error pulses, wrap policy and idle auto-commit.
module morse_entry_buffer #(
    parameter int NUM_SLOTS    = 8,
    parameter int MAX_ELEMS    = 4,
    parameter int LEN_W        = $clog2(MAX_ELEMS + 1),
    parameter int WRAP_ON_FULL = 1,
    parameter int AUTO_COMMIT  = 0
) (
    input logic                  clock,
    input logic                  reset,
    morse_entry_buffer_if.slave  bus
);
    localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
    localparam int IDLE_W = (AUTO_COMMIT > 1) ? $clog2(AUTO_COMMIT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((AUTO_COMMIT > 0) ? AUTO_COMMIT - 1 : 0);

    logic                 r_prevDot, r_prevDash, r_prevCommit, r_prevBack;
    logic [MAX_ELEMS-1:0] r_code [NUM_SLOTS];
    logic [LEN_W-1:0]     r_len  [NUM_SLOTS];
    logic [CNT_W-1:0]     r_count;
    logic [MAX_ELEMS-1:0] r_curCode;
    logic [LEN_W-1:0]     r_curLen;
    logic                 r_err;
    logic [IDLE_W-1:0]    r_idle;

    logic w_edgeDot, w_edgeDash, w_edgeCommit, w_edgeBack;
    logic w_evtBack, w_evtDot, w_evtDash, w_anyEvt;
    logic w_full, w_symEmpty, w_symFull;
    logic w_autoDue, w_doCommit, w_commitOk, w_accept;
    logic [MAX_ELEMS-1:0] w_addMask, w_backMask;
    logic [NUM_SLOTS*MAX_ELEMS-1:0] w_fsmIn;
    logic [NUM_SLOTS*LEN_W-1:0]     w_bits;

    assign w_edgeDot    = bus.btn_dot    & ~r_prevDot;
    assign w_edgeDash   = bus.btn_dash   & ~r_prevDash;
    assign w_edgeCommit = bus.btn_commit & ~r_prevCommit;
    assign w_edgeBack   = bus.btn_back   & ~r_prevBack;

    // Priority commit > back > dot > dash; losing edges are dropped silently.
    assign w_evtBack = w_edgeBack & ~w_edgeCommit;
    assign w_evtDot  = w_edgeDot  & ~w_edgeCommit & ~w_edgeBack;
    assign w_evtDash = w_edgeDash & ~w_edgeCommit & ~w_edgeBack & ~w_edgeDot;
    assign w_anyEvt  = w_edgeDot | w_edgeDash | w_edgeCommit | w_edgeBack;

    assign w_full     = (r_count == CNT_W'(NUM_SLOTS));
    assign w_symEmpty = (r_curLen == '0);
    assign w_symFull  = (r_curLen == LEN_W'(MAX_ELEMS));

    assign w_autoDue  = (AUTO_COMMIT > 0) && !w_symEmpty && (r_idle == IDLE_LAST);
    assign w_doCommit = w_edgeCommit | (w_autoDue & ~w_anyEvt);
    assign w_commitOk = !w_symEmpty && (!w_full || (WRAP_ON_FULL != 0));
    assign w_accept   = (w_doCommit & w_commitOk)
                      | (w_evtBack & (!w_symEmpty || (r_count != '0)))
                      | ((w_evtDot | w_evtDash) & !w_symFull);

    assign w_addMask  = MAX_ELEMS'(1) << r_curLen;
    assign w_backMask = MAX_ELEMS'(1) << (r_curLen - LEN_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prevDot    <= bus.btn_dot;
            r_prevDash   <= bus.btn_dash;
            r_prevCommit <= bus.btn_commit;
            r_prevBack   <= bus.btn_back;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                r_code[k] <= '0;
                r_len[k]  <= '0;
            end
            r_count   <= '0;
            r_curCode <= '0;
            r_curLen  <= '0;
            r_err     <= 1'b0;
            r_idle    <= '0;
        end else begin
            r_prevDot    <= bus.btn_dot;
            r_prevDash   <= bus.btn_dash;
            r_prevCommit <= bus.btn_commit;
            r_prevBack   <= bus.btn_back;
            r_err        <= 1'b0;
            if (w_doCommit) begin
                if (!w_commitOk) begin
                    r_err <= 1'b1;
                end else begin
                    // A commit while full can only get here in wrap mode.
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (w_full) begin
                            r_code[k] <= (k == 0) ? r_curCode : '0;
                            r_len[k]  <= (k == 0) ? r_curLen  : '0;
                        end else if (CNT_W'(k) == r_count) begin
                            r_code[k] <= r_curCode;
                            r_len[k]  <= r_curLen;
                        end
                    end
                    r_count   <= w_full ? CNT_W'(1) : r_count + CNT_W'(1);
                    r_curCode <= '0;
                    r_curLen  <= '0;
                end
            end else if (w_evtBack) begin
                if (!w_symEmpty) begin
                    r_curLen  <= r_curLen - LEN_W'(1);
                    r_curCode <= r_curCode & ~w_backMask;
                end else if (r_count != '0) begin
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (CNT_W'(k) == r_count - CNT_W'(1)) begin
                            r_code[k] <= '0;
                            r_len[k]  <= '0;
                        end
                    end
                    r_count <= r_count - CNT_W'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_evtDot | w_evtDash) begin
                if (w_symFull) begin
                    r_err <= 1'b1;
                end else begin
                    r_curCode <= w_evtDash ? (r_curCode | w_addMask) : (r_curCode & ~w_addMask);
                    r_curLen  <= r_curLen + LEN_W'(1);
                end
            end
            if (w_accept || w_autoDue || w_symEmpty) begin
                r_idle <= '0;
            end else if (r_idle != IDLE_LAST) begin
                r_idle <= r_idle + IDLE_W'(1);
            end
        end
    end

    always_comb begin
        w_fsmIn = '0;
        w_bits  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_fsmIn[k*MAX_ELEMS +: MAX_ELEMS] = r_code[k];
            w_bits[k*LEN_W +: LEN_W]          = r_len[k];
        end
    end

    assign bus.fsm_in   = w_fsmIn;
    assign bus.bits     = w_bits;
    assign bus.count    = r_count;
    assign bus.cur_code = r_curCode;
    assign bus.cur_len  = r_curLen;
    assign bus.full     = w_full;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_morse_entry_buffer.sv
// Directed bench: wrap and no-wrap buffers share one stimulus table; a third
// instance with AUTO_COMMIT=16 exercises the idle timeout.
module tb_morse_entry_buffer;
    localparam logic [3:0] B_DASH   = 4'b0001;
    localparam logic [3:0] B_DOT    = 4'b0010;
    localparam logic [3:0] B_BACK   = 4'b0100;
    localparam logic [3:0] B_COMMIT = 4'b1000;
    localparam logic [3:0] B_NONE   = 4'b0000;

    typedef struct {
        logic [3:0]  btns;
        logic [3:0]  code;
        logic [2:0]  len;
        logic [3:0]  cnt;
        logic        err;
        logic [31:0] fsm;
        logic [23:0] bits;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nTests = 0;
    int   nFail  = 0;
    vec_t vecs [24];

    morse_entry_buffer_if #(.NUM_SLOTS(8), .MAX_ELEMS(4)) ifA ();
    morse_entry_buffer_if #(.NUM_SLOTS(8), .MAX_ELEMS(4)) ifB ();
    morse_entry_buffer_if #(.NUM_SLOTS(8), .MAX_ELEMS(4)) ifC ();

    morse_entry_buffer #(.NUM_SLOTS(8), .MAX_ELEMS(4), .WRAP_ON_FULL(1), .AUTO_COMMIT(0))
        dutA (.clock(clock), .reset(reset), .bus(ifA));
    morse_entry_buffer #(.NUM_SLOTS(8), .MAX_ELEMS(4), .WRAP_ON_FULL(0), .AUTO_COMMIT(0))
        dutB (.clock(clock), .reset(reset), .bus(ifB));
    morse_entry_buffer #(.NUM_SLOTS(8), .MAX_ELEMS(4), .WRAP_ON_FULL(1), .AUTO_COMMIT(16))
        dutC (.clock(clock), .reset(reset), .bus(ifC));

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setAB(input logic [3:0] b);
        ifA.btn_commit = b[3]; ifA.btn_back = b[2]; ifA.btn_dot = b[1]; ifA.btn_dash = b[0];
        ifB.btn_commit = b[3]; ifB.btn_back = b[2]; ifB.btn_dot = b[1]; ifB.btn_dash = b[0];
    endtask

    task automatic setC(input logic [3:0] b);
        ifC.btn_commit = b[3]; ifC.btn_back = b[2]; ifC.btn_dot = b[1]; ifC.btn_dash = b[0];
    endtask

    // Raise the given buttons on A and B; returns #1 after the edge that samples them.
    task automatic applyStimulus(input logic [3:0] b);
        setAB(b);
        step();
    endtask

    task automatic releaseAB();
        setAB(B_NONE);
        step();
    endtask

    task automatic checkVec(input int i);
        checkOutput($sformatf("vec%0d A code", i),  32'(ifA.cur_code), 32'(vecs[i].code));
        checkOutput($sformatf("vec%0d A len", i),   32'(ifA.cur_len),  32'(vecs[i].len));
        checkOutput($sformatf("vec%0d A count", i), 32'(ifA.count),    32'(vecs[i].cnt));
        checkOutput($sformatf("vec%0d A err", i),   32'(ifA.err),      32'(vecs[i].err));
        checkOutput($sformatf("vec%0d A fsm", i),   ifA.fsm_in,        vecs[i].fsm);
        checkOutput($sformatf("vec%0d A bits", i),  32'(ifA.bits),     32'(vecs[i].bits));
        checkOutput($sformatf("vec%0d B code", i),  32'(ifB.cur_code), 32'(vecs[i].code));
        checkOutput($sformatf("vec%0d B len", i),   32'(ifB.cur_len),  32'(vecs[i].len));
        checkOutput($sformatf("vec%0d B count", i), 32'(ifB.count),    32'(vecs[i].cnt));
        checkOutput($sformatf("vec%0d B err", i),   32'(ifB.err),      32'(vecs[i].err));
        checkOutput($sformatf("vec%0d B fsm", i),   ifB.fsm_in,        vecs[i].fsm);
        checkOutput($sformatf("vec%0d B bits", i),  32'(ifB.bits),     32'(vecs[i].bits));
    endtask

    initial begin
        //             btns               code   len   cnt    err   fsm            bits
        vecs[0]  = '{B_DOT,             4'h0, 3'd1, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[1]  = '{B_DASH,            4'h2, 3'd2, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[2]  = '{B_DASH,            4'h6, 3'd3, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[3]  = '{B_COMMIT,          4'h0, 3'd0, 4'd1, 1'b0, 32'h0000_0006, 24'h000003};
        vecs[4]  = '{B_DASH,            4'h1, 3'd1, 4'd1, 1'b0, 32'h0000_0006, 24'h000003};
        vecs[5]  = '{B_DASH,            4'h3, 3'd2, 4'd1, 1'b0, 32'h0000_0006, 24'h000003};
        vecs[6]  = '{B_DASH,            4'h7, 3'd3, 4'd1, 1'b0, 32'h0000_0006, 24'h000003};
        vecs[7]  = '{B_DASH,            4'hF, 3'd4, 4'd1, 1'b0, 32'h0000_0006, 24'h000003};
        vecs[8]  = '{B_DASH,            4'hF, 3'd4, 4'd1, 1'b1, 32'h0000_0006, 24'h000003};
        vecs[9]  = '{B_COMMIT,          4'h0, 3'd0, 4'd2, 1'b0, 32'h0000_00F6, 24'h000023};
        vecs[10] = '{B_DASH,            4'h1, 3'd1, 4'd2, 1'b0, 32'h0000_00F6, 24'h000023};
        vecs[11] = '{B_DOT,             4'h1, 3'd2, 4'd2, 1'b0, 32'h0000_00F6, 24'h000023};
        vecs[12] = '{B_BACK,            4'h1, 3'd1, 4'd2, 1'b0, 32'h0000_00F6, 24'h000023};
        vecs[13] = '{B_BACK,            4'h0, 3'd0, 4'd2, 1'b0, 32'h0000_00F6, 24'h000023};
        vecs[14] = '{B_BACK,            4'h0, 3'd0, 4'd1, 1'b0, 32'h0000_0006, 24'h000003};
        vecs[15] = '{B_BACK,            4'h0, 3'd0, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[16] = '{B_BACK,            4'h0, 3'd0, 4'd0, 1'b1, 32'h0000_0000, 24'h000000};
        vecs[17] = '{B_DOT,             4'h0, 3'd1, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[18] = '{B_DASH,            4'h2, 3'd2, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[19] = '{B_COMMIT | B_DOT,  4'h0, 3'd0, 4'd1, 1'b0, 32'h0000_0002, 24'h000002};
        vecs[20] = '{B_COMMIT,          4'h0, 3'd0, 4'd1, 1'b1, 32'h0000_0002, 24'h000002};
        vecs[21] = '{B_BACK | B_DASH,   4'h0, 3'd0, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[22] = '{B_DOT | B_DASH,    4'h0, 3'd1, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};
        vecs[23] = '{B_BACK,            4'h0, 3'd0, 4'd0, 1'b0, 32'h0000_0000, 24'h000000};

        setAB(B_NONE);
        setC(B_NONE);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        checkOutput("reset A fsm",   ifA.fsm_in,        32'h0);
        checkOutput("reset A bits",  32'(ifA.bits),     32'h0);
        checkOutput("reset A count", 32'(ifA.count),    32'h0);
        checkOutput("reset A len",   32'(ifA.cur_len),  32'h0);
        checkOutput("reset A code",  32'(ifA.cur_code), 32'h0);
        checkOutput("reset A full",  32'(ifA.full),     32'h0);
        checkOutput("reset A err",   32'(ifA.err),      32'h0);
        checkOutput("reset B count", 32'(ifB.count),    32'h0);
        checkOutput("reset C count", 32'(ifC.count),    32'h0);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].btns);
            checkVec(i);
            releaseAB();
            checkOutput($sformatf("vec%0d A err clear", i), 32'(ifA.err), 32'h0);
        end

        // Fill all eight slots with a single dash each.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(B_DASH);
            releaseAB();
            applyStimulus(B_COMMIT);
            releaseAB();
        end
        checkOutput("fill A full",  32'(ifA.full),  32'h1);
        checkOutput("fill A count", 32'(ifA.count), 32'h8);
        checkOutput("fill A fsm",   ifA.fsm_in,     32'h1111_1111);
        checkOutput("fill A bits",  32'(ifA.bits),  32'h249249);
        checkOutput("fill B full",  32'(ifB.full),  32'h1);
        checkOutput("fill B fsm",   ifB.fsm_in,     32'h1111_1111);

        applyStimulus(B_DOT);
        releaseAB();
        applyStimulus(B_COMMIT);
        checkOutput("wrap A fsm",   ifA.fsm_in,        32'h0);
        checkOutput("wrap A bits",  32'(ifA.bits),     32'h1);
        checkOutput("wrap A count", 32'(ifA.count),    32'h1);
        checkOutput("wrap A full",  32'(ifA.full),     32'h0);
        checkOutput("wrap A err",   32'(ifA.err),      32'h0);
        checkOutput("wrap A len",   32'(ifA.cur_len),  32'h0);
        checkOutput("nowrap B err",   32'(ifB.err),     32'h1);
        checkOutput("nowrap B fsm",   ifB.fsm_in,       32'h1111_1111);
        checkOutput("nowrap B bits",  32'(ifB.bits),    32'h249249);
        checkOutput("nowrap B count", 32'(ifB.count),   32'h8);
        checkOutput("nowrap B len",   32'(ifB.cur_len), 32'h1);
        checkOutput("nowrap B full",  32'(ifB.full),    32'h1);
        releaseAB();
        checkOutput("nowrap B err clear", 32'(ifB.err), 32'h0);

        // Mid-symbol reset with dot held: nothing survives and the release does not fire.
        applyStimulus(B_DASH);
        releaseAB();
        setAB(B_DOT);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        checkOutput("held A len",   32'(ifA.cur_len), 32'h0);
        checkOutput("held A count", 32'(ifA.count),   32'h0);
        checkOutput("held A fsm",   ifA.fsm_in,       32'h0);
        checkOutput("held B len",   32'(ifB.cur_len), 32'h0);
        checkOutput("held B count", 32'(ifB.count),   32'h0);
        releaseAB();
        checkOutput("held release A len", 32'(ifA.cur_len), 32'h0);
        applyStimulus(B_DOT);
        checkOutput("after held A len", 32'(ifA.cur_len), 32'h1);
        releaseAB();

        // Auto-commit: dot edge at E, commit lands at E+16.
        setC(B_DOT);
        step();
        checkOutput("auto dot len", 32'(ifC.cur_len), 32'h1);
        setC(B_NONE);
        repeat (15) step();
        checkOutput("auto E+15 count", 32'(ifC.count),   32'h0);
        checkOutput("auto E+15 len",   32'(ifC.cur_len), 32'h1);
        step();
        checkOutput("auto E+16 count", 32'(ifC.count),   32'h1);
        checkOutput("auto E+16 len",   32'(ifC.cur_len), 32'h0);
        checkOutput("auto E+16 bits",  32'(ifC.bits),    32'h1);
        checkOutput("auto E+16 err",   32'(ifC.err),     32'h0);

        // Dash at E+10 restarts the idle count; commit lands at E+26.
        setC(B_DOT);
        step();
        setC(B_NONE);
        repeat (9) step();
        setC(B_DASH);
        step();
        checkOutput("restart dash len", 32'(ifC.cur_len), 32'h2);
        setC(B_NONE);
        repeat (6) step();
        checkOutput("restart E+16 count", 32'(ifC.count),   32'h1);
        checkOutput("restart E+16 len",   32'(ifC.cur_len), 32'h2);
        repeat (9) step();
        checkOutput("restart E+25 count", 32'(ifC.count), 32'h1);
        step();
        checkOutput("restart E+26 count", 32'(ifC.count),   32'h2);
        checkOutput("restart E+26 fsm",   ifC.fsm_in,       32'h20);
        checkOutput("restart E+26 bits",  32'(ifC.bits),    32'h11);
        checkOutput("restart E+26 len",   32'(ifC.cur_len), 32'h0);

        setC(B_COMMIT);
        step();
        checkOutput("empty commit err",   32'(ifC.err),   32'h1);
        checkOutput("empty commit count", 32'(ifC.count), 32'h2);
        checkOutput("empty commit fsm",   ifC.fsm_in,     32'h20);
        setC(B_NONE);
        step();
        checkOutput("empty commit err clear", 32'(ifC.err), 32'h0);
        repeat (20) step();
        checkOutput("idle empty count", 32'(ifC.count), 32'h2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/morse_entry_buffer.md
Name: morse_entry_buffer

Overview:
Parametrised successor to the fixed 8-slot Morse entry block. It captures dot/dash button presses into a current symbol and commits symbols into a NUM_SLOTS-deep buffer. The packed buffer outputs (per-slot code and length) feed the Morse decode FSM and the anode display. New relative to the fixed block:
- element-level backspace
- rejection of empty commits and over-length symbols, with an error pulse
- selectable full-buffer policy
- optional idle auto-commit

Parameters:
NUM_SLOTS, 8, number of symbol slots in the buffer (1..16)
MAX_ELEMS, 4, maximum dots/dashes per symbol (1..8)
LEN_W, $clog2(MAX_ELEMS+1), width of a per-slot length field
WRAP_ON_FULL, 1, 1 = commit when full clears the buffer and writes slot 0; 0 = commit when full is rejected with err
AUTO_COMMIT, 0, idle cycles before the current symbol auto-commits; 0 = disabled

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
btn_dot  in  1  level input; rising edge adds a dot (0)
btn_dash  in  1  level input; rising edge adds a dash (1)
btn_commit  in  1  level input; rising edge commits the current symbol
btn_back  in  1  level input; rising edge performs backspace
fsm_in  out  NUM_SLOTS*MAX_ELEMS  packed symbol codes; slot k = [k*MAX_ELEMS +: MAX_ELEMS]
bits  out  NUM_SLOTS*LEN_W  packed element counts; slot k = [k*LEN_W +: LEN_W]
count  out  $clog2(NUM_SLOTS+1)  number of committed slots
cur_code  out  MAX_ELEMS  symbol under construction
cur_len  out  LEN_W  elements in the current symbol
full  out  1  count == NUM_SLOTS
err  out  1  one-cycle pulse on a rejected action

Behaviour:
- Reset (synchronous, active-high) clears all outputs and state to 0. During reset, the edge-history registers load the current button levels, so a button held through reset does not fire on release.
- Edge detect: an event is btn=1 while its previous-cycle sample=0. The state update happens at the same posedge the edge is sampled. All outputs are registered and visible the cycle after that edge.
- One event per cycle. Priority: commit > back > dot > dash. Lower-priority edges in the same cycle are discarded without err.
- Dot/dash:
  - If cur_len < MAX_ELEMS: set cur_code[cur_len] = 0 (dot) or 1 (dash), then cur_len += 1.
  - If cur_len == MAX_ELEMS: no state change, err=1.
- Commit:
  - If cur_len == 0: ignored, err=1.
  - If not full: write cur_code/cur_len to slot[count], count += 1, clear cur_code/cur_len.
  - If full and WRAP_ON_FULL=1: zero all slots, write slot 0, count = 1.
  - If full and WRAP_ON_FULL=0: buffer unchanged, current symbol retained, err=1.
- Back:
  - If cur_len > 0: cur_len -= 1 and cur_code[cur_len-1] = 0.
  - Else if count > 0: count -= 1 and zero slot[count-1] (code and length).
  - Else: err=1.
- Auto-commit (AUTO_COMMIT > 0):
  - An idle counter resets on any accepted event or when cur_len == 0. Otherwise it increments and saturates.
  - Reaching AUTO_COMMIT-1 with cur_len > 0 triggers a commit on that cycle, with the same rules as a button commit.
  - A button event in the same cycle takes precedence, and the counter resets.
- Unused slots always read 0. Element bit 0 = first element entered. Only the low LEN_W bits of each length field are meaningful.
- err is high for exactly one cycle per rejected action, and 0 otherwise.
- Reset asserted mid-symbol or mid-timeout discards everything; there is no partial commit.

Test Plan:
1. Default params; after reset press dot, dash, dash, then commit -> slot0 code=4'b0110, len=3; count=1; cur_len=0; all other slots 0.
2. Press dash ×5 -> after 4th press cur_code=4'b1111, cur_len=4; 5th press gives err pulse, state unchanged; commit -> slot0 len=4.
3. Commit 8 symbols (full=1), then a 9th "dot" with WRAP_ON_FULL=1 -> only slot0 nonzero (code 0, len 1), count=1, full=0. With WRAP_ON_FULL=0 -> err pulse, all 8 slots retained, cur_len stays 1.
4. Enter dash, dot, then back -> cur_code=4'b0001, cur_len=1. Back twice more -> cur_len=0 on the first; the second removes the last committed slot (count decrements, slot zeroed). Back at count=0, cur_len=0 -> err.
5. btn_commit and btn_dot rise in the same cycle with cur_len=2 -> commit only, dot discarded. btn_dot held high through reset -> no element added after reset release.
6. AUTO_COMMIT=16: enter dot then idle -> auto-commit exactly 16 cycles after the dot edge, count=1. A dash at cycle 10 restarts the count; commit 16 cycles after the dash. Commit with cur_len=0 -> err pulse, no slot written.
